// File: rtl/stim_pulse_monitor.sv
// Biphasic stimulation pulse monitor: measures phase-1, inter-phase gap and
// phase-2 lengths plus pulse period, and flags imbalance, channel and
// magnitude inconsistencies per pulse.
module stim_pulse_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BAL_TOL = 2,
  parameter int unsigned IPD_MAX = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_ST,
  input  logic [4:0]       MAG_ST,
  input  logic [2:0]       ChSel_HS,
  input  logic [2:0]       ChSel_LS,
  output logic             PULSE_VALID,
  output logic [CNT_W-1:0] PH1_LEN,
  output logic [CNT_W-1:0] IPD_LEN,
  output logic [CNT_W-1:0] PH2_LEN,
  output logic [CNT_W-1:0] PERIOD_LEN,
  output logic             PERIOD_VALID,
  output logic             BAL_ERR,
  output logic             CH_ERR,
  output logic             MAG_ERR,
  output logic             ABORT,
  output logic [15:0]      PULSE_CNT
);

  typedef enum logic [2:0] {StIdle, StPh1, StIpd, StPh2, StRest} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   IpdMax = (CNT_W+1)'(IPD_MAX);
  localparam logic [CNT_W:0]   BalTol = (CNT_W+1)'(BAL_TOL);

  state_e           state_q;
  logic [CNT_W-1:0] ph_cnt_q;      // shared by phase 1 and phase 2
  logic [CNT_W-1:0] ph1_len_q;
  logic [CNT_W-1:0] gap_cnt_q;     // also holds the gap length during phase 2
  logic [CNT_W-1:0] period_cnt_q;
  logic             period_run_q;  // a previous phase-1 start exists
  logic [2:0]       ref_hs_q;
  logic [2:0]       ref_ls_q;
  logic [4:0]       ref_mag_q;
  logic [2:0]       ph2_hs_q;
  logic [2:0]       ph2_ls_q;
  logic             ch_acc_q;
  logic             mag_acc_q;

  // Saturating increment; counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CntOne;
  endfunction

  logic [CNT_W:0] bal_diff;
  logic [CNT_W:0] bal_abs;
  logic           bal_over;
  logic           ph1_ch_chg;
  logic           ph2_ch_chg;
  logic           swap_bad;
  logic           mag_chg;

  // Phase balance evaluated one bit wider so the difference cannot overflow.
  always_comb begin
    bal_diff = {1'b0, ph1_len_q} - {1'b0, ph_cnt_q};
    bal_abs  = bal_diff[CNT_W] ? -bal_diff : bal_diff;
    bal_over = bal_abs > BalTol;
  end

  // Consistency checks of the live inputs against captured references.
  always_comb begin
    ph1_ch_chg = (ChSel_HS != ref_hs_q) || (ChSel_LS != ref_ls_q);
    ph2_ch_chg = (ChSel_HS != ph2_hs_q) || (ChSel_LS != ph2_ls_q);
    swap_bad   = (ChSel_HS != ref_ls_q) || (ChSel_LS != ref_hs_q);
    mag_chg    = MAG_ST != ref_mag_q;
  end

  // Pulse FSM with measurement counters and registered report outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      ph_cnt_q     <= '0;
      ph1_len_q    <= '0;
      gap_cnt_q    <= '0;
      period_cnt_q <= '0;
      period_run_q <= 1'b0;
      ref_hs_q     <= '0;
      ref_ls_q     <= '0;
      ref_mag_q    <= '0;
      ph2_hs_q     <= '0;
      ph2_ls_q     <= '0;
      ch_acc_q     <= 1'b0;
      mag_acc_q    <= 1'b0;
      PULSE_VALID  <= 1'b0;
      PH1_LEN      <= '0;
      IPD_LEN      <= '0;
      PH2_LEN      <= '0;
      PERIOD_LEN   <= '0;
      PERIOD_VALID <= 1'b0;
      BAL_ERR      <= 1'b0;
      CH_ERR       <= 1'b0;
      MAG_ERR      <= 1'b0;
      ABORT        <= 1'b0;
      PULSE_CNT    <= '0;
    end else begin
      PULSE_VALID  <= 1'b0;
      PERIOD_VALID <= 1'b0;
      ABORT        <= 1'b0;
      if (period_run_q) begin
        period_cnt_q <= sat_inc(period_cnt_q);
      end

      unique case (state_q)
        StIdle, StRest: begin
          if (EN_ST) begin
            state_q      <= StPh1;
            ph_cnt_q     <= CntOne;
            ref_hs_q     <= ChSel_HS;
            ref_ls_q     <= ChSel_LS;
            ref_mag_q    <= MAG_ST;
            ch_acc_q     <= 1'b0;
            mag_acc_q    <= 1'b0;
            // Aborted pulses restart the period too; only the very first
            // phase-1 start after reset has no predecessor to measure from.
            period_cnt_q <= CntOne;
            period_run_q <= 1'b1;
            if (period_run_q) begin
              PERIOD_LEN   <= period_cnt_q;
              PERIOD_VALID <= 1'b1;
            end
          end
        end
        StPh1: begin
          if (EN_ST) begin
            ph_cnt_q <= sat_inc(ph_cnt_q);
            if (ph1_ch_chg) ch_acc_q  <= 1'b1;
            if (mag_chg)    mag_acc_q <= 1'b1;
          end else begin
            state_q   <= StIpd;
            ph1_len_q <= ph_cnt_q;
            gap_cnt_q <= CntOne;
          end
        end
        StIpd: begin
          if (EN_ST) begin
            state_q  <= StPh2;
            ph_cnt_q <= CntOne;
            ph2_hs_q <= ChSel_HS;
            ph2_ls_q <= ChSel_LS;
            if (swap_bad) ch_acc_q  <= 1'b1;
            if (mag_chg)  mag_acc_q <= 1'b1;
          end else if ({1'b0, gap_cnt_q} >= IpdMax) begin
            // This low sample would take the gap past the limit.
            state_q <= StRest;
            ABORT   <= 1'b1;
          end else begin
            gap_cnt_q <= sat_inc(gap_cnt_q);
          end
        end
        StPh2: begin
          if (EN_ST) begin
            ph_cnt_q <= sat_inc(ph_cnt_q);
            if (ph2_ch_chg) ch_acc_q  <= 1'b1;
            if (mag_chg)    mag_acc_q <= 1'b1;
          end else begin
            state_q     <= StRest;
            PULSE_VALID <= 1'b1;
            PH1_LEN     <= ph1_len_q;
            IPD_LEN     <= gap_cnt_q;
            PH2_LEN     <= ph_cnt_q;
            BAL_ERR     <= bal_over;
            CH_ERR      <= ch_acc_q;
            MAG_ERR     <= mag_acc_q;
            PULSE_CNT   <= PULSE_CNT + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
